// File: rtl/ascensor_pkg.sv
// ascensor_pkg
// Shared definitions for the elevator controller chain (request memory and
// motion controller): FSM state encoding, motion action codes, request
// instruction codes and the code-to-floor decoder.
package ascensor_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        PUERTA   = 2'd3
    } estado_t;

    // Motion action seen by the request memory. 3 is never driven.
    localparam logic [1:0] ACC_IDLE = 2'd0;
    localparam logic [1:0] ACC_SUBE = 2'd1;
    localparam logic [1:0] ACC_BAJA = 2'd2;

    // Next-instruction codes produced by the request memory.
    localparam logic [3:0] COD_NADA    = 4'd0;
    localparam logic [3:0] COD_CAB_1   = 4'd1;
    localparam logic [3:0] COD_CAB_2   = 4'd2;
    localparam logic [3:0] COD_CAB_3   = 4'd3;
    localparam logic [3:0] COD_CAB_4   = 4'd4;
    localparam logic [3:0] COD_P1_SUBE = 4'd5;
    localparam logic [3:0] COD_P2_BAJA = 4'd6;
    localparam logic [3:0] COD_P2_SUBE = 4'd7;
    localparam logic [3:0] COD_P3_BAJA = 4'd8;
    localparam logic [3:0] COD_P3_SUBE = 4'd9;
    localparam logic [3:0] COD_P4_BAJA = 4'd10;

    // Returns {valid, floor}. Codes 0 and 11..15 are "no request".
    function automatic logic [2:0] piso_de_codigo(input logic [3:0] codigo);
        logic [2:0] res;
        res = 3'b000;
        case (codigo)
            COD_CAB_1, COD_P1_SUBE:              res = {1'b1, 2'd0};
            COD_CAB_2, COD_P2_BAJA, COD_P2_SUBE: res = {1'b1, 2'd1};
            COD_CAB_3, COD_P3_BAJA, COD_P3_SUBE: res = {1'b1, 2'd2};
            COD_CAB_4, COD_P4_BAJA:              res = {1'b1, 2'd3};
            default:                             res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/temporizador.sv
// temporizador
// Loadable down-counter. Loads `valor` when `carga` is high, otherwise
// counts down and holds at zero.
// Ports:
//   clk, rst   clock, synchronous active-high reset (count -> 0)
//   carga      load strobe
//   valor      load value
//   hecho      high while the count is zero
module temporizador #(
    parameter int ANCHO = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             carga,
    input  logic [ANCHO-1:0] valor,
    output logic             hecho
);

    logic [ANCHO-1:0] cuenta;

    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta <= '0;
        end else if (carga) begin
            cuenta <= valor;
        end else if (cuenta != '0) begin
            cuenta <= cuenta - ANCHO'(1);
        end
    end

    assign hecho = (cuenta == '0);

endmodule

// File: rtl/control_movimiento.sv
// control_movimiento
// Elevator car motion controller. Reads the next-instruction code from the
// request memory and drives floor position, motion action and door state,
// which feed back to the request memory.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   memoria_in   next-instruction code (0 none, 1..10 requests, 11..15 none)
//   piso         current floor 0..3
//   accion       0 idle, 1 up, 2 down
//   puertas      1 = door open
//   arribo       one-cycle pulse on each floor arrival
//   estado       current FSM state (observation only)
module control_movimiento
    import ascensor_pkg::*;
#(
    parameter int T_PISO   = 8,
    parameter int T_PUERTA = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] memoria_in,
    output logic [1:0] piso,
    output logic [1:0] accion,
    output logic       puertas,
    output logic       arribo,
    output estado_t    estado
);

    localparam int ANCHO_PISO   = $clog2(T_PISO);
    localparam int ANCHO_PUERTA = $clog2(T_PUERTA);
    localparam logic [ANCHO_PISO-1:0]   CARGA_PISO   = ANCHO_PISO'(T_PISO - 1);
    localparam logic [ANCHO_PUERTA-1:0] CARGA_PUERTA = ANCHO_PUERTA'(T_PUERTA - 1);

    estado_t    estado_sig;
    logic [1:0] piso_sig;
    logic [1:0] accion_sig;
    logic       puertas_sig;
    logic       arribo_sig;
    logic [1:0] objetivo;
    logic [1:0] objetivo_sig;
    logic       carga_viaje;
    logic       carga_puerta;
    logic       fin_viaje;
    logic       fin_puerta;

    logic [2:0] decod;
    logic       pedido_valido;
    logic [1:0] pedido_piso;

    assign decod         = piso_de_codigo(memoria_in);
    assign pedido_valido = decod[2];
    assign pedido_piso   = decod[1:0];

    temporizador #(.ANCHO(ANCHO_PISO)) u_viaje (
        .clk   (clk),
        .rst   (rst),
        .carga (carga_viaje),
        .valor (CARGA_PISO),
        .hecho (fin_viaje)
    );

    temporizador #(.ANCHO(ANCHO_PUERTA)) u_puerta (
        .clk   (clk),
        .rst   (rst),
        .carga (carga_puerta),
        .valor (CARGA_PUERTA),
        .hecho (fin_puerta)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= IDLE;
            piso     <= 2'd0;
            accion   <= ACC_IDLE;
            puertas  <= 1'b0;
            arribo   <= 1'b0;
            objetivo <= 2'd0;
        end else begin
            estado   <= estado_sig;
            piso     <= piso_sig;
            accion   <= accion_sig;
            puertas  <= puertas_sig;
            arribo   <= arribo_sig;
            objetivo <= objetivo_sig;
        end
    end

    always_comb begin
        estado_sig   = estado;
        piso_sig     = piso;
        accion_sig   = accion;
        puertas_sig  = puertas;
        arribo_sig   = 1'b0;
        objetivo_sig = objetivo;
        carga_viaje  = 1'b0;
        carga_puerta = 1'b0;

        case (estado)
            IDLE: begin
                accion_sig  = ACC_IDLE;
                puertas_sig = 1'b0;
                if (pedido_valido) begin
                    objetivo_sig = pedido_piso;
                    if (pedido_piso == piso) begin
                        estado_sig   = PUERTA;
                        puertas_sig  = 1'b1;
                        carga_puerta = 1'b1;
                    end else if (pedido_piso > piso) begin
                        estado_sig  = SUBIENDO;
                        accion_sig  = ACC_SUBE;
                        carga_viaje = 1'b1;
                    end else begin
                        estado_sig  = BAJANDO;
                        accion_sig  = ACC_BAJA;
                        carga_viaje = 1'b1;
                    end
                end
            end

            SUBIENDO, BAJANDO: begin
                if (arribo) begin
                    // Arrival cycle: the request memory already sees the new
                    // floor, so its code decides an intermediate stop. The
                    // travel timer was reloaded on the arrival edge, so
                    // continuing costs no extra cycle.
                    if ((piso == objetivo) || (pedido_valido && (pedido_piso == piso))) begin
                        estado_sig   = PUERTA;
                        accion_sig   = ACC_IDLE;
                        puertas_sig  = 1'b1;
                        carga_puerta = 1'b1;
                    end
                end else if (fin_viaje) begin
                    piso_sig    = (estado == SUBIENDO) ? piso + 2'd1 : piso - 2'd1;
                    arribo_sig  = 1'b1;
                    carga_viaje = 1'b1;
                end
            end

            PUERTA: begin
                accion_sig = ACC_IDLE;
                if (fin_puerta) begin
                    puertas_sig = 1'b0;
                    // A retained target means an intermediate stop: resume.
                    if (objetivo > piso) begin
                        estado_sig  = SUBIENDO;
                        accion_sig  = ACC_SUBE;
                        carga_viaje = 1'b1;
                    end else if (objetivo < piso) begin
                        estado_sig  = BAJANDO;
                        accion_sig  = ACC_BAJA;
                        carga_viaje = 1'b1;
                    end else begin
                        estado_sig = IDLE;
                    end
                end
            end

            default: estado_sig = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_movimiento.sv
module tb_control_movimiento;
  import ascensor_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] memoria_in = 4'd0;
  logic [1:0] piso;
  logic [1:0] accion;
  logic       puertas;
  logic       arribo;
  estado_t    estado;

  int errores = 0;
  int checks  = 0;
  int pulsos  = 0;

  control_movimiento #(.T_PISO(4), .T_PUERTA(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .memoria_in (memoria_in),
    .piso       (piso),
    .accion     (accion),
    .puertas    (puertas),
    .arribo     (arribo),
    .estado     (estado)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] m;
    logic [1:0] p;
    logic [1:0] a;
    logic       pu;
    logic       ar;
    estado_t    st;
  } vec_t;

  vec_t tabla[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nombre, input int got, input int exp_v);
    checks++;
    if (got != exp_v) begin
      errores++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nombre, got, exp_v, $time);
    end
  endtask

  task automatic ver(input string nombre, input int ep, input int ea, input int epu,
                     input int ear, input estado_t est);
    chk({nombre, ".piso"}, piso, ep);
    chk({nombre, ".accion"}, accion, ea);
    chk({nombre, ".puertas"}, puertas, epu);
    chk({nombre, ".arribo"}, arribo, ear);
    chk({nombre, ".estado"}, int'(estado), int'(est));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    memoria_in = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // door stays open: one sample already taken, n more open, then closes
  task automatic puerta_abierta(input string nombre, input int p, input int resto);
    for (int i = 0; i < resto; i++) begin
      tick();
      ver(nombre, p, 0, 1, 0, PUERTA);
    end
  endtask

  initial begin
    // reset and long idle
    reset_dut();
    ver("reset", 0, 0, 0, 0, IDLE);
    for (int i = 0; i < 50; i++) begin
      tick();
      ver("idle50", 0, 0, 0, 0, IDLE);
    end

    // table: reset, invalid codes, request at current floor, one floor up
    tabla[0]  = '{1'b1, 4'd0,  2'd0, 2'd0, 1'b0, 1'b0, IDLE};
    tabla[1]  = '{1'b1, 4'd0,  2'd0, 2'd0, 1'b0, 1'b0, IDLE};
    tabla[2]  = '{1'b0, 4'd0,  2'd0, 2'd0, 1'b0, 1'b0, IDLE};
    tabla[3]  = '{1'b0, 4'd13, 2'd0, 2'd0, 1'b0, 1'b0, IDLE};
    tabla[4]  = '{1'b0, 4'd15, 2'd0, 2'd0, 1'b0, 1'b0, IDLE};
    tabla[5]  = '{1'b0, 4'd5,  2'd0, 2'd0, 1'b1, 1'b0, PUERTA};
    for (int i = 6; i <= 10; i++)
      tabla[i] = '{1'b0, 4'd0, 2'd0, 2'd0, 1'b1, 1'b0, PUERTA};
    tabla[11] = '{1'b0, 4'd0,  2'd0, 2'd0, 1'b0, 1'b0, IDLE};
    tabla[12] = '{1'b0, 4'd2,  2'd0, 2'd1, 1'b0, 1'b0, SUBIENDO};
    for (int i = 13; i <= 15; i++)
      tabla[i] = '{1'b0, 4'd0, 2'd0, 2'd1, 1'b0, 1'b0, SUBIENDO};
    tabla[16] = '{1'b0, 4'd0,  2'd1, 2'd1, 1'b0, 1'b1, SUBIENDO};
    tabla[17] = '{1'b0, 4'd0,  2'd1, 2'd0, 1'b1, 1'b0, PUERTA};

    for (int i = 0; i < 18; i++) begin
      rst = tabla[i].r;
      memoria_in = tabla[i].m;
      tick();
      ver($sformatf("vec%0d", i), tabla[i].p, tabla[i].a, tabla[i].pu, tabla[i].ar, tabla[i].st);
    end

    // multi-floor up 0 -> 3
    reset_dut();
    memoria_in = 4'd4;
    tick();
    ver("up.start", 0, 1, 0, 0, SUBIENDO);
    memoria_in = 4'd0;
    pulsos = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (arribo) pulsos++;
      ver($sformatf("up.k%0d", k), k / 4, 1, 0, (k % 4 == 0) ? 1 : 0, SUBIENDO);
    end
    chk("up.pulsos", pulsos, 3);
    tick();
    ver("up.door", 3, 0, 1, 0, PUERTA);
    puerta_abierta("up.open", 3, 5);
    tick();
    ver("up.idle", 3, 0, 0, 0, IDLE);

    // down 3 -> 0 with intermediate stop at floor 1 (code 6)
    memoria_in = 4'd1;
    tick();
    ver("dn.start", 3, 2, 0, 0, BAJANDO);
    memoria_in = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ver($sformatf("dn.k%0d", k), 3 - k / 4, 2, 0, (k % 4 == 0) ? 1 : 0, BAJANDO);
    end
    memoria_in = 4'd6;  // arrival cycle at floor 1
    tick();
    ver("dn.stop", 1, 0, 1, 0, PUERTA);
    memoria_in = 4'd0;
    puerta_abierta("dn.open", 1, 5);
    tick();
    ver("dn.resume", 1, 2, 0, 0, BAJANDO);
    memoria_in = 4'd2;  // same-floor code mid-travel must be ignored
    for (int k = 1; k <= 3; k++) begin
      tick();
      ver($sformatf("dn.r%0d", k), 1, 2, 0, 0, BAJANDO);
    end
    memoria_in = 4'd0;
    tick();
    ver("dn.arr0", 0, 2, 0, 1, BAJANDO);
    tick();
    ver("dn.door0", 0, 0, 1, 0, PUERTA);
    puerta_abierta("dn.open0", 0, 5);
    tick();
    ver("dn.idle", 0, 0, 0, 0, IDLE);

    // reach floor 2, then reset 2 cycles into an up trip
    memoria_in = 4'd3;
    tick();
    memoria_in = 4'd0;
    for (int k = 1; k <= 9; k++) tick();
    ver("to2.door", 2, 0, 1, 0, PUERTA);
    puerta_abierta("to2.open", 2, 5);
    tick();
    ver("to2.idle", 2, 0, 0, 0, IDLE);
    memoria_in = 4'd10;
    tick();
    ver("rs.start", 2, 1, 0, 0, SUBIENDO);
    memoria_in = 4'd0;
    tick();
    tick();
    ver("rs.mid", 2, 1, 0, 0, SUBIENDO);
    rst = 1'b1;
    tick();
    ver("rs.reset", 0, 0, 0, 0, IDLE);
    rst = 1'b0;
    tick();
    ver("rs.after", 0, 0, 0, 0, IDLE);

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule
